// File: rtl/sample_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : sample_mac_acc
// Summary  : Accumulates LEN signed products, then emits a shifted, saturated
//            result through a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module sample_mac_acc #(
    parameter int DIN_WIDTH = 14,
    parameter int LEN       = 16,
    parameter int ACC_WIDTH = 24,
    parameter int SHIFT     = 0,
    parameter int OUT_WIDTH = 14
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic signed [DIN_WIDTH-1:0] prod_din,
    input  logic                        prod_valid,
    output logic                        prod_ready,
    input  logic                        acc_clr,
    output logic signed [OUT_WIDTH-1:0] acc_dout,
    output logic                        acc_valid,
    input  logic                        acc_ready,
    output logic                        acc_ovf,
    output logic                        busy
);

    localparam int c_cnt_w = $clog2(LEN);
    localparam int c_ext_w = (ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(LEN - 1);
    localparam logic signed [c_ext_w-1:0] c_max =
        {{(c_ext_w - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [c_ext_w-1:0] c_min =
        {{(c_ext_w - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    if (ACC_WIDTH < DIN_WIDTH + $clog2(LEN)) begin : g_acc_width_check
        $error("sample_mac_acc: ACC_WIDTH too small for DIN_WIDTH and LEN");
    end

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_run;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic        [c_cnt_w-1:0]   r_cnt;
    logic signed [OUT_WIDTH-1:0] r_dout;
    logic                        r_ovf;

    logic                        w_accept;
    logic                        w_last;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic signed [c_ext_w-1:0]   w_ext;
    logic                        w_hi;
    logic                        w_lo;
    logic signed [OUT_WIDTH-1:0] w_sat;

    // r_run holds prod_ready low until the first edge after reset release
    assign prod_ready = r_run && (r_state == ST_ACC) && !acc_clr;
    assign acc_valid  = (r_state == ST_OUT);
    assign acc_dout   = r_dout;
    assign acc_ovf    = r_ovf;
    assign busy       = (r_cnt != '0) || acc_valid;

    assign w_accept   = prod_valid && prod_ready;
    assign w_last     = (r_cnt == c_last);
    assign w_prod_ext = ACC_WIDTH'(prod_din);
    assign w_sum      = r_acc + w_prod_ext;
    assign w_shifted  = w_sum >>> SHIFT;
    assign w_ext      = c_ext_w'(w_shifted);
    assign w_hi       = (w_ext > c_max);
    assign w_lo       = (w_ext < c_min);
    assign w_sat      = w_hi ? c_max[OUT_WIDTH-1:0] :
                        w_lo ? c_min[OUT_WIDTH-1:0] : w_ext[OUT_WIDTH-1:0];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (acc_clr) begin
            w_state_nxt = ST_ACC;
        end else begin
            case (r_state)
                ST_ACC:  if (w_accept && w_last) w_state_nxt = ST_OUT;
                ST_OUT:  if (acc_ready) w_state_nxt = ST_ACC;
                default: w_state_nxt = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_run  <= 1'b0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (acc_clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_acc  <= '0;
                    r_cnt  <= '0;
                    r_dout <= w_sat;
                    r_ovf  <= w_hi || w_lo;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
